l2_flush_engine: RTL and testbench
==================================

Name: l2_flush_engine

Overview:
Parametrised flush/writeback sequencer for the L2 cache. It walks every set and way of the tag/state memory after a flush request. Clean valid lines are invalidated in place. Modified lines become writeback (PutM) requests, with a bounded number in flight. It generalises the fixed flush_set/flush_way iteration in the L2 controller to arbitrary geometry, adds a data-only mode and outstanding-writeback throttling, and sits between the L2 FSM and the local tag/state memory.

Parameters:
SETS, 256, number of sets (power of 2, >=2); SET_BITS = log2(SETS)
WAYS, 8, associativity (power of 2, >=2); WAY_BITS = log2(WAYS)
TAG_BITS, 20, tag width
MAX_OUT, 4, maximum outstanding writebacks (>=1); CNT_BITS = log2(MAX_OUT)+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush_valid  in  1  flush request
flush_all  in  1  1 = flush all lines; 0 = data lines only (hprot=1), sampled on accept
flush_ready  out  1  engine idle, can accept
rd_en  out  1  memory read strobe
rd_set  out  SET_BITS  read set index
rd_way  out  WAY_BITS  read way index
rd_state  in  2  line state, valid 1 cycle after rd_en (0=I,1=S,2=E,3=M)
rd_tag  in  TAG_BITS  line tag, same timing
rd_hprot  in  1  line hprot, same timing
wr_inval_en  out  1  write state I to (rd_set, rd_way)
evict_valid  out  1  writeback request valid
evict_ready  in  1  writeback request accepted
evict_addr  out  TAG_BITS+SET_BITS  {tag,set} of the evicted line
evict_done  in  1  one-cycle pulse: a writeback completed (PutAck)
busy  out  1  engine not IDLE
flush_done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: state IDLE; set/way counters 0; outstanding counter 0; mode 0. All outputs 0 except flush_ready=1. Reset applies mid-walk with no drain; the pending evict_valid drops immediately.
- IDLE: flush_ready=1. On flush_valid & flush_ready: latch flush_all, clear set/way, go to READ.
- READ: rd_en=1 with the current set/way. Next state is CHECK.
- CHECK (read data valid this cycle):
  - Skip the line (ADVANCE, no write) if rd_state==I, or if mode==0 and rd_hprot==0.
  - If rd_state is S or E: wr_inval_en=1 this cycle, then ADVANCE.
  - If rd_state is M and outstanding==MAX_OUT: stay in CHECK, holding the captured tag. Re-read is not required; tag/state are registered on the first CHECK cycle.
  - If rd_state is M and outstanding<MAX_OUT: go to ISSUE.
- ISSUE: evict_valid=1 with evict_addr={captured tag, set}, held stable until evict_ready. On the handshake cycle: wr_inval_en=1, outstanding+1, then ADVANCE.
- ADVANCE (combinational step inside CHECK/ISSUE):
  - If way<WAYS-1: way+1, go to READ.
  - Else if set<SETS-1: way=0, set+1, go to READ.
  - Else: go to DRAIN.
  - Counters never wrap past their last index.
- DRAIN: wait until outstanding==0, then go to DONE. If outstanding is already 0 on entry, DONE follows next cycle.
- DONE: flush_done=1 for exactly 1 cycle, then IDLE. Done-to-ready latency is 1 cycle.
- Outstanding counter:
  - +1 on evict handshake; -1 on evict_done.
  - Simultaneous handshake and evict_done: no change.
  - evict_done with counter 0 is ignored; the assertion fires in simulation.
  - evict_done is honoured in every state, including IDLE.
- busy = (state != IDLE).
- flush_valid is ignored while busy. flush_ready=0 outside IDLE.
- Minimum latency, all lines invalid: 2*SETS*WAYS + 2 cycles from accept to flush_done.

Test Plan:
- All 2048 lines invalid (SETS=256, WAYS=8), flush_all=1 -> no wr_inval_en, no evict_valid; flush_done exactly 4098 cycles after accept.
- Set 5 way 3 = S, set 9 way 0 = E -> exactly two wr_inval_en pulses at those indices; no evicts.
- Set 7 way 2 = M with tag 0x12345, evict_ready=1, evict_done 10 cycles later -> evict_addr={0x12345,7}, one wr_inval_en; flush_done only after evict_done.
- MAX_OUT=4, 6 M lines, evict_done withheld -> exactly 4 handshakes, engine stalls in CHECK. Releasing one evict_done -> 5th evict issues.
- flush_all=0, M line with hprot=0 and M line with hprot=1 -> only the hprot=1 line is evicted.
- Reset asserted mid-ISSUE with evict_ready=0 -> evict_valid=0 immediately, flush_ready=1, outstanding=0. Evict_done pulse in the same cycle as a handshake -> counter unchanged.

Source files
------------

// File: rtl/l2_flush_engine_if.sv
// Bundle between the L2 flush engine, the L2 FSM, the tag/state memory and the writeback path.
interface l2_flush_engine_if #(
  parameter int unsigned SET_BITS = 8,
  parameter int unsigned WAY_BITS = 3,
  parameter int unsigned TAG_BITS = 20
);
  logic                         flush_valid;
  logic                         flush_all;
  logic                         flush_ready;
  logic                         rd_en;
  logic [SET_BITS-1:0]          rd_set;
  logic [WAY_BITS-1:0]          rd_way;
  logic [1:0]                   rd_state;
  logic [TAG_BITS-1:0]          rd_tag;
  logic                         rd_hprot;
  logic                         wr_inval_en;
  logic                         evict_valid;
  logic                         evict_ready;
  logic [TAG_BITS+SET_BITS-1:0] evict_addr;
  logic                         evict_done;
  logic                         busy;
  logic                         flush_done;

  modport master (
    input  flush_valid, flush_all, rd_state, rd_tag, rd_hprot, evict_ready, evict_done,
    output flush_ready, rd_en, rd_set, rd_way, wr_inval_en, evict_valid, evict_addr,
           busy, flush_done
  );

  modport slave (
    output flush_valid, flush_all, rd_state, rd_tag, rd_hprot, evict_ready, evict_done,
    input  flush_ready, rd_en, rd_set, rd_way, wr_inval_en, evict_valid, evict_addr,
           busy, flush_done
  );
endinterface

// File: rtl/l2_flush_engine.sv
// Walks every set/way of the L2 tag/state memory: invalidates clean lines in place and
// turns modified lines into throttled PutM writebacks, then drains before signalling done.
module l2_flush_engine #(
  parameter int unsigned SETS     = 256,
  parameter int unsigned WAYS     = 8,
  parameter int unsigned TAG_BITS = 20,
  parameter int unsigned MAX_OUT  = 4
) (
  input logic               clk,
  input logic               rst,
  l2_flush_engine_if.master bus
);
  localparam int unsigned SET_BITS = $clog2(SETS);
  localparam int unsigned WAY_BITS = $clog2(WAYS);
  localparam int unsigned CNT_BITS = $clog2(MAX_OUT) + 1;
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);
  localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);
  localparam logic [CNT_BITS-1:0] MAX_CNT  = CNT_BITS'(MAX_OUT);
  localparam logic [1:0]          ST_I     = 2'd0;
  localparam logic [1:0]          ST_M     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t              state, state_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [WAY_BITS-1:0] way_q, way_d;
  logic [CNT_BITS-1:0] outstanding;
  logic                mode_q;
  logic                first_q;
  logic [TAG_BITS-1:0] cap_tag;
  logic [1:0]          cap_state;
  logic                cap_hprot;

  logic       accept, advance, evict_hs, dec, rd_en_c, inval_c, evict_valid_c;
  logic [1:0] line_state;
  logic       line_hprot;

  // Read data is live only in the first CHECK cycle; stalled cycles use the captured copy.
  assign line_state = first_q ? bus.rd_state : cap_state;
  assign line_hprot = first_q ? bus.rd_hprot : cap_hprot;

  always_comb begin
    state_d       = state;
    set_d         = set_q;
    way_d         = way_q;
    accept        = 1'b0;
    advance       = 1'b0;
    evict_hs      = 1'b0;
    rd_en_c       = 1'b0;
    inval_c       = 1'b0;
    evict_valid_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.flush_valid) begin
          accept  = 1'b1;
          set_d   = '0;
          way_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_en_c = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (line_state == ST_I || (!mode_q && !line_hprot)) begin
          advance = 1'b1;
        end else if (line_state != ST_M) begin
          inval_c = 1'b1;
          advance = 1'b1;
        end else if (outstanding < MAX_CNT) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        evict_valid_c = 1'b1;
        if (bus.evict_ready) begin
          evict_hs = 1'b1;
          inval_c  = 1'b1;
          advance  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (outstanding == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Way-major walk that stops at the last line instead of wrapping.
    if (advance) begin
      if (way_q != LAST_WAY) begin
        way_d   = way_q + WAY_BITS'(1);
        state_d = S_READ;
      end else if (set_q != LAST_SET) begin
        way_d   = '0;
        set_d   = set_q + SET_BITS'(1);
        state_d = S_READ;
      end else begin
        state_d = S_DRAIN;
      end
    end
  end

  // A completion coinciding with a handshake cancels it; a stray completion at zero is dropped.
  assign dec = bus.evict_done && (outstanding != '0 || evict_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      set_q       <= '0;
      way_q       <= '0;
      outstanding <= '0;
      mode_q      <= 1'b0;
      first_q     <= 1'b0;
      cap_tag     <= '0;
      cap_state   <= ST_I;
      cap_hprot   <= 1'b0;
    end else begin
      state   <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      first_q <= (state == S_READ);
      if (accept) mode_q <= bus.flush_all;
      if (first_q) begin
        cap_tag   <= bus.rd_tag;
        cap_state <= bus.rd_state;
        cap_hprot <= bus.rd_hprot;
      end
      case ({evict_hs, dec})
        2'b10:   outstanding <= outstanding + CNT_BITS'(1);
        2'b01:   outstanding <= outstanding - CNT_BITS'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign bus.flush_ready = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.flush_done  = (state == S_DONE);
  assign bus.rd_en       = rd_en_c;
  assign bus.rd_set      = set_q;
  assign bus.rd_way      = way_q;
  assign bus.wr_inval_en = inval_c;
  assign bus.evict_valid = evict_valid_c;
  assign bus.evict_addr  = {cap_tag, set_q};

  a_done_underflow: assert property (@(posedge clk) disable iff (rst)
    !(bus.evict_done && outstanding == '0 && !evict_hs));
endmodule

// File: tb/tb_l2_flush_engine.sv
// Directed bench for l2_flush_engine: tag/state memory model plus per-scenario tasks.
module tb_l2_flush_engine;
  localparam int unsigned SETS = 256, WAYS = 8, TAG_BITS = 20, MAX_OUT = 4;
  localparam int unsigned SET_BITS = 8, WAY_BITS = 3, LINES = SETS * WAYS;
  localparam int unsigned ADDR_BITS = TAG_BITS + SET_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_flush_engine_if #(.SET_BITS(SET_BITS), .WAY_BITS(WAY_BITS), .TAG_BITS(TAG_BITS)) bus();

  l2_flush_engine #(.SETS(SETS), .WAYS(WAYS), .TAG_BITS(TAG_BITS), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int inval_cnt = 0;
  int hs_cnt = 0;
  int dones_given = 0;

  logic [1:0]           mem_state [LINES];
  logic [TAG_BITS-1:0]  mem_tag   [LINES];
  logic                 mem_hprot [LINES];
  int                   inval_log [16];
  logic [ADDR_BITS-1:0] hs_log    [16];

  logic                 poke_en = 1'b0;
  logic                 clear_all = 1'b0;
  int                   poke_idx = 0;
  logic [1:0]           poke_state = 2'd0;
  logic [TAG_BITS-1:0]  poke_tag = '0;
  logic                 poke_hprot = 1'b0;
  logic [SET_BITS+WAY_BITS-1:0] cur_idx;
  assign cur_idx = {bus.rd_set, bus.rd_way};

  // Memory with one-cycle read latency, plus logs of invalidations and evict handshakes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clear_all) begin
      for (int i = 0; i < LINES; i++) begin
        mem_state[i] <= 2'd0;
        mem_tag[i]   <= '0;
        mem_hprot[i] <= 1'b0;
      end
    end else if (poke_en) begin
      mem_state[poke_idx] <= poke_state;
      mem_tag[poke_idx]   <= poke_tag;
      mem_hprot[poke_idx] <= poke_hprot;
    end
    if (bus.rd_en) begin
      bus.rd_state <= mem_state[cur_idx];
      bus.rd_tag   <= mem_tag[cur_idx];
      bus.rd_hprot <= mem_hprot[cur_idx];
    end
    if (bus.wr_inval_en) begin
      mem_state[cur_idx]     <= 2'd0;
      inval_log[inval_cnt % 16] <= int'(cur_idx);
      inval_cnt <= inval_cnt + 1;
    end
    if (bus.evict_valid && bus.evict_ready) begin
      hs_log[hs_cnt % 16] <= bus.evict_addr;
      hs_cnt <= hs_cnt + 1;
    end
  end

  task automatic clear_mem();
    @(negedge clk); clear_all = 1'b1;
    @(negedge clk); clear_all = 1'b0;
  endtask

  task automatic poke(input int idx, input logic [1:0] st, input logic [TAG_BITS-1:0] tag,
                      input logic hp);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_state = st; poke_tag = tag; poke_hprot = hp;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic start_flush(input logic all, output int scyc);
    @(negedge clk);
    bus.flush_all = all; bus.flush_valid = 1'b1; scyc = cyc;
    @(negedge clk);
    bus.flush_valid = 1'b0; bus.flush_all = 1'b0;
  endtask

  // Waits for flush_done, optionally returning completions for every outstanding writeback.
  task automatic run_to_done(input bit drain, input int budget, output int dcyc);
    bit seen = 1'b0;
    bit pulsed = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      bus.evict_done = 1'b0;
      if (bus.flush_done === 1'b1) begin
        seen = 1'b1; dcyc = cyc;
      end else if (drain && !pulsed && (hs_cnt - dones_given) > 0) begin
        bus.evict_done = 1'b1; dones_given++; pulsed = 1'b1;
      end else begin
        pulsed = 1'b0;
      end
    end
    bus.evict_done = 1'b0;
    checks++;
    if (!seen) begin
      failures++; $display("FAIL flush_done_timeout got=none required=pulse within %0d cycles", budget);
    end else begin
      checks++;
      if ((hs_cnt - dones_given) != 0) begin
        failures++; $display("FAIL done_before_drain outstanding=%0d required=0", hs_cnt - dones_given);
      end
      @(negedge clk);
      checks++;
      if (bus.flush_done !== 1'b0 || bus.flush_ready !== 1'b1) begin
        failures++; $display("FAIL done_to_ready done=%0b ready=%0b required done=0 ready=1",
                             bus.flush_done, bus.flush_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush_valid = 1'b0; bus.flush_all = 1'b0; bus.evict_ready = 1'b0; bus.evict_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.flush_ready, bus.busy, bus.rd_en, bus.wr_inval_en, bus.evict_valid, bus.flush_done} !== 6'b100000) begin
      failures++; $display("FAIL reset_outputs got=%b required=100000",
        {bus.flush_ready, bus.busy, bus.rd_en, bus.wr_inval_en, bus.evict_valid, bus.flush_done});
    end
    checks++;
    if (bus.rd_set !== 8'd0 || bus.rd_way !== 3'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d required=0/0", bus.rd_set, bus.rd_way);
    end
  endtask

  task automatic test_all_invalid();
    int s, d, ib, hb;
    clear_mem();
    ib = inval_cnt; hb = hs_cnt;
    checks++;
    if (bus.flush_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready got=%b required=1", bus.flush_ready);
    end
    start_flush(1'b1, s);
    bus.flush_valid = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (bus.flush_ready !== 1'b0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL walk_busy ready=%b busy=%b required ready=0 busy=1", bus.flush_ready, bus.busy);
    end
    bus.flush_valid = 1'b0;
    run_to_done(1'b0, 5000, d);
    checks++;
    if (d - s != 4098) begin
      failures++; $display("FAIL all_invalid_latency got=%0d required=4098", d - s);
    end
    checks++;
    if (inval_cnt != ib || hs_cnt != hb) begin
      failures++; $display("FAIL all_invalid_activity inval=%0d evicts=%0d required 0/0", inval_cnt - ib, hs_cnt - hb);
    end
  endtask

  task automatic test_clean_inval();
    int s, d, ib, hb;
    clear_mem();
    poke(5 * 8 + 3, 2'd1, 20'h00AAA, 1'b1);
    poke(9 * 8 + 0, 2'd2, 20'h00BBB, 1'b0);
    ib = inval_cnt; hb = hs_cnt;
    start_flush(1'b1, s);
    run_to_done(1'b0, 5000, d);
    checks++;
    if (inval_cnt - ib != 2) begin
      failures++; $display("FAIL clean_inval_count got=%0d required=2", inval_cnt - ib);
    end
    checks++;
    if (inval_log[ib % 16] != 43 || inval_log[(ib + 1) % 16] != 72) begin
      failures++; $display("FAIL clean_inval_index got=%0d,%0d required=43,72",
                           inval_log[ib % 16], inval_log[(ib + 1) % 16]);
    end
    checks++;
    if (hs_cnt != hb || mem_state[43] !== 2'd0 || mem_state[72] !== 2'd0) begin
      failures++; $display("FAIL clean_no_evict evicts=%0d st43=%0d st72=%0d required 0/0/0",
                           hs_cnt - hb, mem_state[43], mem_state[72]);
    end
  endtask

  task automatic test_single_evict();
    int s, d, ib, hb;
    bit got = 1'b0;
    bit early = 1'b0;
    clear_mem();
    poke(7 * 8 + 2, 2'd3, 20'h12345, 1'b1);
    ib = inval_cnt; hb = hs_cnt;
    bus.evict_ready = 1'b1;
    start_flush(1'b1, s);
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (hs_cnt - hb == 1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL single_evict_timeout got=none required=handshake");
    end
    repeat (9) begin
      @(negedge clk);
      if (bus.flush_done === 1'b1) early = 1'b1;
    end
    @(negedge clk); bus.evict_done = 1'b1; dones_given++;
    @(negedge clk); bus.evict_done = 1'b0;
    run_to_done(1'b1, 5000, d);
    checks++;
    if (hs_cnt - hb != 1 || hs_log[hb % 16] !== {20'h12345, 8'd7}) begin
      failures++; $display("FAIL single_evict_addr count=%0d addr=%h required 1/%h",
                           hs_cnt - hb, hs_log[hb % 16], {20'h12345, 8'd7});
    end
    checks++;
    if (inval_cnt - ib != 1 || mem_state[58] !== 2'd0 || early) begin
      failures++; $display("FAIL single_evict_inval inval=%0d st=%0d early=%0b required 1/0/0",
                           inval_cnt - ib, mem_state[58], early);
    end
  endtask

  task automatic test_throttle();
    int s, d, hb;
    bit got = 1'b0;
    bit moved = 1'b0;
    clear_mem();
    for (int w = 0; w < 6; w++) poke(20 * 8 + w, 2'd3, 20'hA0000 + 20'(w), 1'b1);
    hb = hs_cnt;
    bus.evict_ready = 1'b1;
    start_flush(1'b1, s);
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (hs_cnt - hb == 4) got = 1'b1;
    end
    repeat (3) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      if (bus.rd_en !== 1'b0 || bus.evict_valid !== 1'b0) moved = 1'b1;
    end
    checks++;
    if (hs_cnt - hb != 4 || moved || bus.busy !== 1'b1) begin
      failures++; $display("FAIL throttle_stall evicts=%0d moved=%0b busy=%b required 4/0/1",
                           hs_cnt - hb, moved, bus.busy);
    end
    @(negedge clk); bus.evict_done = 1'b1; dones_given++;
    @(negedge clk); bus.evict_done = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (hs_cnt - hb != 5 || hs_log[(hb + 4) % 16] !== {20'hA0004, 8'd20}) begin
      failures++; $display("FAIL throttle_release evicts=%0d addr=%h required 5/%h",
                           hs_cnt - hb, hs_log[(hb + 4) % 16], {20'hA0004, 8'd20});
    end
    run_to_done(1'b1, 6000, d);
    checks++;
    if (hs_cnt - hb != 6) begin
      failures++; $display("FAIL throttle_total got=%0d required=6", hs_cnt - hb);
    end
  endtask

  task automatic test_back_to_back_done();
    int s, d, hb;
    bit did = 1'b0;
    clear_mem();
    for (int w = 0; w < 6; w++) poke(40 * 8 + w, 2'd3, 20'hB0000 + 20'(w), 1'b1);
    hb = hs_cnt;
    bus.evict_ready = 1'b1;
    start_flush(1'b1, s);
    for (int i = 0; i < 2000 && !did; i++) begin
      @(negedge clk);
      if (bus.evict_valid === 1'b1 && hs_cnt - hb == 3) begin
        bus.evict_done = 1'b1; dones_given++; did = 1'b1;
      end
    end
    @(negedge clk); bus.evict_done = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (!did || hs_cnt - hb != 5) begin
      failures++; $display("FAIL simultaneous_done aligned=%0b evicts=%0d required 1/5", did, hs_cnt - hb);
    end
    run_to_done(1'b1, 6000, d);
    checks++;
    if (hs_cnt - hb != 6) begin
      failures++; $display("FAIL simultaneous_total got=%0d required=6", hs_cnt - hb);
    end
  endtask

  task automatic test_data_only();
    int s, d, ib, hb;
    clear_mem();
    poke(30 * 8 + 1, 2'd3, 20'h0BEEF, 1'b0);
    poke(31 * 8 + 6, 2'd3, 20'h0CAFE, 1'b1);
    ib = inval_cnt; hb = hs_cnt;
    bus.evict_ready = 1'b1;
    start_flush(1'b0, s);
    run_to_done(1'b1, 5000, d);
    checks++;
    if (hs_cnt - hb != 1 || hs_log[hb % 16] !== {20'h0CAFE, 8'd31}) begin
      failures++; $display("FAIL data_only_evict count=%0d addr=%h required 1/%h",
                           hs_cnt - hb, hs_log[hb % 16], {20'h0CAFE, 8'd31});
    end
    checks++;
    if (inval_cnt - ib != 1 || mem_state[241] !== 2'd3 || mem_state[254] !== 2'd0) begin
      failures++; $display("FAIL data_only_state inval=%0d st241=%0d st254=%0d required 1/3/0",
                           inval_cnt - ib, mem_state[241], mem_state[254]);
    end
  endtask

  task automatic test_reset_mid_issue();
    int s, d, hb;
    bit got = 1'b0;
    clear_mem();
    poke(99 * 8, 2'd3, 20'h11111, 1'b1);
    poke(100 * 8, 2'd3, 20'h22222, 1'b1);
    for (int w = 0; w < 3; w++) poke(101 * 8 + w, 2'd3, 20'h33330 + 20'(w), 1'b1);
    hb = hs_cnt;
    bus.evict_ready = 1'b1;
    start_flush(1'b1, s);
    for (int i = 0; i < 2500 && !got; i++) begin
      @(negedge clk);
      if (hs_cnt - hb == 1) bus.evict_ready = 1'b0;
      if (bus.evict_ready === 1'b0 && bus.evict_valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL mid_issue_timeout got=none required=pending evict");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.evict_valid !== 1'b0 || bus.flush_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_issue valid=%b ready=%b busy=%b required 0/1/0",
                           bus.evict_valid, bus.flush_ready, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    dones_given = hs_cnt;
    bus.evict_ready = 1'b1;
    hb = hs_cnt;
    got = 1'b0;
    start_flush(1'b1, s);
    for (int i = 0; i < 2500 && !got; i++) begin
      @(negedge clk);
      if (hs_cnt - hb == 4) got = 1'b1;
    end
    checks++;
    if (hs_cnt - hb != 4 || hs_log[hb % 16] !== {20'h22222, 8'd100}) begin
      failures++; $display("FAIL post_reset_outstanding evicts=%0d first=%h required 4/%h",
                           hs_cnt - hb, hs_log[hb % 16], {20'h22222, 8'd100});
    end
    run_to_done(1'b1, 6000, d);
  endtask

  initial begin
    test_reset();
    test_all_invalid();
    test_clean_inval();
    test_single_evict();
    test_throttle();
    test_back_to_back_done();
    test_data_only();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
